// File: rtl/pixel_replication_nx.sv
// Integer-factor zoom by pixel replication: each input row is captured in a
// register line buffer, then replayed N times with every pixel repeated N times.
module pixel_replication_nx #(
  parameter int PIXEL_W    = 8,
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120,
  parameter int MAX_FACTOR = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         factor,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIXEL_W-1:0] in_pixel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIXEL_W-1:0] out_pixel,
  output logic               out_eol,
  output logic               out_eof,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int REP_W = (MAX_FACTOR > 1) ? $clog2(MAX_FACTOR) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  state_t             state_reg, state_next;
  logic [2:0]         n_reg, n_next;
  logic [COL_W-1:0]   in_col_reg, in_col_next;
  logic [COL_W-1:0]   out_col_reg, out_col_next;
  logic [REP_W-1:0]   rep_x_reg, rep_x_next;
  logic [REP_W-1:0]   rep_y_reg, rep_y_next;
  logic [ROW_W-1:0]   row_reg, row_next;
  logic               err_flag_reg, err_flag_next;
  logic [PIXEL_W-1:0] linebuf_reg [IMG_W];

  logic factor_ok;
  logic in_col_last, out_col_last, rep_x_last, rep_y_last, row_last;
  logic load_fire, emit_fire;

  // factor is judged at its full 3-bit width, so 0 and anything above MAX_FACTOR fail
  assign factor_ok    = (factor != 3'd0) && (32'(factor) <= MAX_FACTOR);
  assign in_col_last  = (in_col_reg == COL_W'(IMG_W - 1));
  assign out_col_last = (out_col_reg == COL_W'(IMG_W - 1));
  assign rep_x_last   = (3'(rep_x_reg) == (n_reg - 3'd1));
  assign rep_y_last   = (3'(rep_y_reg) == (n_reg - 3'd1));
  assign row_last     = (row_reg == ROW_W'(IMG_H - 1));
  assign load_fire    = (state_reg == LOAD) && in_valid;
  assign emit_fire    = (state_reg == EMIT) && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      n_reg        <= 3'd0;
      in_col_reg   <= '0;
      out_col_reg  <= '0;
      rep_x_reg    <= '0;
      rep_y_reg    <= '0;
      row_reg      <= '0;
      err_flag_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      n_reg        <= n_next;
      in_col_reg   <= in_col_next;
      out_col_reg  <= out_col_next;
      rep_x_reg    <= rep_x_next;
      rep_y_reg    <= rep_y_next;
      row_reg      <= row_next;
      err_flag_reg <= err_flag_next;
    end
  end

  // Line buffer holds no reset: it is always fully reloaded before being replayed
  always_ff @(posedge clk) begin
    if (load_fire) begin
      linebuf_reg[in_col_reg] <= in_pixel;
    end
  end

  always_comb begin
    state_next    = state_reg;
    n_next        = n_reg;
    in_col_next   = in_col_reg;
    out_col_next  = out_col_reg;
    rep_x_next    = rep_x_reg;
    rep_y_next    = rep_y_reg;
    row_next      = row_reg;
    err_flag_next = err_flag_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (factor_ok) begin
            n_next       = factor;
            in_col_next  = '0;
            out_col_next = '0;
            rep_x_next   = '0;
            rep_y_next   = '0;
            row_next     = '0;
            state_next   = LOAD;
          end else begin
            err_flag_next = 1'b1;
            state_next    = DONE;
          end
        end
      end

      LOAD: begin
        if (in_valid) begin
          if (in_col_last) begin
            in_col_next = '0;
            state_next  = EMIT;
          end else begin
            in_col_next = in_col_reg + 1'b1;
          end
        end
      end

      EMIT: begin
        if (out_ready) begin
          if (!rep_x_last) begin
            rep_x_next = rep_x_reg + 1'b1;
          end else begin
            rep_x_next = '0;
            if (!out_col_last) begin
              out_col_next = out_col_reg + 1'b1;
            end else begin
              out_col_next = '0;
              if (!rep_y_last) begin
                // replay the same buffered row
                rep_y_next = rep_y_reg + 1'b1;
              end else begin
                rep_y_next = '0;
                if (row_last) begin
                  row_next   = '0;
                  state_next = DONE;
                end else begin
                  row_next   = row_reg + 1'b1;
                  state_next = LOAD;
                end
              end
            end
          end
        end
      end

      DONE: begin
        err_flag_next = 1'b0;
        state_next    = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == LOAD);
    out_valid = (state_reg == EMIT);
    out_pixel = (state_reg == EMIT) ? linebuf_reg[out_col_reg] : '0;
    out_eol   = (state_reg == EMIT) && out_col_last && rep_x_last;
    out_eof   = out_eol && rep_y_last && row_last;
    busy      = (state_reg != IDLE);
    done      = (state_reg == DONE);
    err       = (state_reg == DONE) && err_flag_reg;
  end

endmodule
